arb8_sched: RTL and testbench
=============================

Name: arb8_sched

Overview:
- Registered 8-requester arbiter that grants one shared resource at a time. Default policy is fixed priority, with the highest index winning (same ordering as the penc8 priority encoder).
- Optional round-robin mode.
- A grant is held until the owner releases it, drops its request, or exceeds a hold-time limit.
- Sits between client request lines and the shared datapath. gnt_id drives the datapath select mux.

Parameters:
MAX_HOLD, 16, maximum consecutive cycles a grant may be held before forced release (legal range 2..255)
CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req  input  8  request lines; req[i]=1 means client i wants the resource
done  input  1  owner releases the grant this cycle
mode  input  1  0 = fixed priority, 1 = round-robin; sampled only in IDLE
gnt  output  8  one-hot grant, registered
gnt_id  output  3  binary index of the current owner; valid only when gnt_valid=1
gnt_valid  output  1  1 while any grant is active (equals |gnt)
timeout  output  1  single-cycle pulse when a grant is force-released
hold_cnt  output  CNT_W  cycles the current grant has been held; 0 in IDLE

Behaviour:
- Reset is asynchronous and active-low. One clock, clk.
- While rst_n=0:
  - gnt=0, gnt_id=0, gnt_valid=0, timeout=0, hold_cnt=0.
  - state=IDLE, last_id=0.
- Asserting reset mid-grant clears gnt immediately, without waiting for a clock edge.
- The state machine has two states: IDLE and BUSY.
- IDLE:
  - If req==0: stay in IDLE with outputs at 0.
  - Otherwise pick a winner w per policy. At that clock edge: gnt <= 1<<w, gnt_id <= w, gnt_valid <= 1, hold_cnt <= 1, last_id <= w, go to BUSY.
  - Latency is 1 cycle from req sampled high to gnt visible.
- Fixed policy: w is the highest set index of req.
- Round-robin policy:
  - Search order is last_id-1, last_id-2, ... descending mod 8, ending at last_id itself.
  - With last_id=0 after reset, the order is 7..0, which is identical to fixed priority.
- BUSY: the grant is held while none of the release conditions below are met, and hold_cnt increments each cycle.
- Release conditions, evaluated each edge in priority order:
  - (a) done=1, or (b) req[gnt_id]=0: normal release, timeout stays 0.
  - (c) hold_cnt==MAX_HOLD: forced release, with timeout=1 for exactly the following cycle.
  - On any release: gnt <= 0, gnt_valid <= 0, hold_cnt <= 0, go to IDLE.
- After each release there is one mandatory idle cycle, so back-to-back grants are separated by exactly one cycle with gnt=0.
- A grant lasts at most MAX_HOLD cycles.
- If done arrives on the same edge where hold_cnt==MAX_HOLD, done wins and no timeout pulse is produced.
- done is ignored in IDLE.
- New or changed req bits from non-owners during BUSY have no effect until the next IDLE arbitration.
- Changing mode during BUSY has no effect until the next IDLE.
- gnt is always one-hot or zero. gnt_id holds its last value in IDLE; consumers qualify it with gnt_valid.
- No combinational path from req or done to any output; all outputs come directly from flops.

Test Plan:
- Reset: drive rst_n=0 mid-grant (gnt=8'h20) -> gnt=0, gnt_valid=0 asynchronously. After release with req=0 -> outputs stay 0.
- Fixed priority sweep: mode=0; for each req value 1..255, pulse done after 1 cycle of grant -> gnt_id equals the highest set bit of req, gnt is one-hot, grant appears 1 cycle after req, 1 idle cycle between grants.
- Round-robin fairness: mode=1, req=8'hFF held, done pulsed every grant -> gnt_id sequence 7,6,5,4,3,2,1,0,7 with one idle cycle between grants.
- Timeout: MAX_HOLD=16, req=8'h04 held, done=0 -> gnt=8'h04 for 16 cycles, then gnt=0 with timeout=1 for exactly 1 cycle, then re-grant to 2 one cycle later.
- Request drop: owner 5 granted (req=8'h21), drop req[5] -> gnt=0 on the next edge, timeout=0; next grant goes to 0.
- Collision: done=1 on the cycle hold_cnt==16 -> release occurs with timeout=0. Mode toggled during BUSY -> current grant is unaffected.

Source files
------------

// File: rtl/arb8_sched.sv
// 8-requester registered arbiter: fixed-priority (highest index) or round-robin,
// with grant hold until done, request drop, or MAX_HOLD-cycle forced release.
module arb8_sched #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       req,
    input  logic             done,
    input  logic             mode,
    output logic [7:0]       gnt,
    output logic [2:0]       gnt_id,
    output logic             gnt_valid,
    output logic             timeout,
    output logic [CNT_W-1:0] hold_cnt
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [7:0]       gnt_q, gnt_d;
    logic [2:0]       gnt_id_q, gnt_id_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [2:0]       last_id_q, last_id_d;

    logic [2:0] fix_w, rr_w, rr_idx, win;
    logic       rel_norm, rel_force;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            hold_cnt_q  <= '0;
            last_id_q   <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            hold_cnt_q  <= hold_cnt_d;
            last_id_q   <= last_id_d;
        end
    end

    // Winner selection; round-robin walks last_id-1 downward, ending at last_id,
    // so the nearest candidate (smallest offset) is applied last and wins.
    always_comb begin
        fix_w  = '0;
        rr_w   = '0;
        rr_idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (req[i]) fix_w = 3'(i);
        end
        for (int k = 8; k >= 1; k--) begin
            rr_idx = last_id_q - 3'(k);
            if (req[rr_idx]) rr_w = rr_idx;
        end
        win = mode ? rr_w : fix_w;
    end

    // Release priority: done / owner drop beats the hold limit
    assign rel_norm  = done || !req[gnt_id_q];
    assign rel_force = (hold_cnt_q == CNT_W'(MAX_HOLD));

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        hold_cnt_d  = hold_cnt_q;
        last_id_d   = last_id_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d     = BUSY;
                    gnt_d       = 8'(1) << win;
                    gnt_id_d    = win;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = CNT_W'(1);
                    last_id_d   = win;
                end
            end
            BUSY: begin
                if (rel_norm || rel_force) begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    hold_cnt_d  = '0;
                    timeout_d   = !rel_norm;
                end else begin
                    hold_cnt_d  = hold_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs straight from flops
    always_comb begin
        gnt       = gnt_q;
        gnt_id    = gnt_id_q;
        gnt_valid = gnt_valid_q;
        timeout   = timeout_q;
        hold_cnt  = hold_cnt_q;
    end

endmodule

// File: tb/tb_arb8_sched.sv
// Directed bench for arb8_sched: vector table plus hand-written timeout,
// collision, mode-toggle and asynchronous-reset sequences.
module tb_arb8_sched;

    localparam int MAX_HOLD = 16;
    localparam int CNT_W    = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [7:0]       req = '0;
    logic             done = 1'b0;
    logic             mode = 1'b0;
    logic [7:0]       gnt;
    logic [2:0]       gnt_id;
    logic             gnt_valid;
    logic             timeout;
    logic [CNT_W-1:0] hold_cnt;

    int checks = 0;
    int failures = 0;

    arb8_sched #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done), .mode(mode),
        .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid),
        .timeout(timeout), .hold_cnt(hold_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] req;
        logic       done;
        logic       mode;
        logic [7:0] gnt;
        logic [2:0] id;
        logic       vld;
        logic       tmo;
        logic [7:0] hc;
    } vec_t;

    vec_t tv[24];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] eg, input logic [2:0] eid,
                       input logic ev, input logic eto, input logic [7:0] ehc);
        checks++;
        if (gnt !== eg || gnt_id !== eid || gnt_valid !== ev || timeout !== eto ||
            hold_cnt !== CNT_W'(ehc)) begin
            failures++;
            $display("FAIL %s: got gnt=%h id=%0d vld=%b tmo=%b hc=%0d, want gnt=%h id=%0d vld=%b tmo=%b hc=%0d",
                     name, gnt, gnt_id, gnt_valid, timeout, hold_cnt, eg, eid, ev, eto, ehc);
        end
    endtask

    function automatic logic [2:0] hb(input logic [7:0] r);
        logic [2:0] h = '0;
        for (int i = 0; i < 8; i++) if (r[i]) h = 3'(i);
        return h;
    endfunction

    initial begin
        // Round-robin from reset (last_id=0): 7..0 then back to 7
        tv[0]  = '{8'hFF, 1'b0, 1'b1, 8'h80, 3'd7, 1'b1, 1'b0, 8'd1};
        tv[1]  = '{8'hFF, 1'b1, 1'b1, 8'h00, 3'd7, 1'b0, 1'b0, 8'd0};
        tv[2]  = '{8'hFF, 1'b0, 1'b1, 8'h40, 3'd6, 1'b1, 1'b0, 8'd1};
        tv[3]  = '{8'hFF, 1'b1, 1'b1, 8'h00, 3'd6, 1'b0, 1'b0, 8'd0};
        tv[4]  = '{8'hFF, 1'b0, 1'b1, 8'h20, 3'd5, 1'b1, 1'b0, 8'd1};
        tv[5]  = '{8'hFF, 1'b1, 1'b1, 8'h00, 3'd5, 1'b0, 1'b0, 8'd0};
        tv[6]  = '{8'hFF, 1'b0, 1'b1, 8'h10, 3'd4, 1'b1, 1'b0, 8'd1};
        tv[7]  = '{8'hFF, 1'b1, 1'b1, 8'h00, 3'd4, 1'b0, 1'b0, 8'd0};
        tv[8]  = '{8'hFF, 1'b0, 1'b1, 8'h08, 3'd3, 1'b1, 1'b0, 8'd1};
        tv[9]  = '{8'hFF, 1'b1, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0, 8'd0};
        tv[10] = '{8'hFF, 1'b0, 1'b1, 8'h04, 3'd2, 1'b1, 1'b0, 8'd1};
        tv[11] = '{8'hFF, 1'b1, 1'b1, 8'h00, 3'd2, 1'b0, 1'b0, 8'd0};
        tv[12] = '{8'hFF, 1'b0, 1'b1, 8'h02, 3'd1, 1'b1, 1'b0, 8'd1};
        tv[13] = '{8'hFF, 1'b1, 1'b1, 8'h00, 3'd1, 1'b0, 1'b0, 8'd0};
        tv[14] = '{8'hFF, 1'b0, 1'b1, 8'h01, 3'd0, 1'b1, 1'b0, 8'd1};
        tv[15] = '{8'hFF, 1'b1, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 8'd0};
        tv[16] = '{8'hFF, 1'b0, 1'b1, 8'h80, 3'd7, 1'b1, 1'b0, 8'd1};
        tv[17] = '{8'hFF, 1'b1, 1'b1, 8'h00, 3'd7, 1'b0, 1'b0, 8'd0};
        // Owner drop: 5 granted, req[5] falls, next grant goes to 0
        tv[18] = '{8'h21, 1'b0, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0, 8'd1};
        tv[19] = '{8'h21, 1'b0, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0, 8'd2};
        tv[20] = '{8'h01, 1'b0, 1'b0, 8'h00, 3'd5, 1'b0, 1'b0, 8'd0};
        tv[21] = '{8'h01, 1'b0, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0, 8'd1};
        tv[22] = '{8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 8'd0};
        tv[23] = '{8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 8'd0};

        // Reset
        #1 rst_n = 1'b0;
        #1 chk("reset_async", 8'h00, 3'd0, 1'b0, 1'b0, 8'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_hold", 8'h00, 3'd0, 1'b0, 1'b0, 8'd0);

        // Vector table
        for (int i = 0; i < 24; i++) begin
            req = tv[i].req; done = tv[i].done; mode = tv[i].mode;
            step();
            chk($sformatf("vec%0d", i), tv[i].gnt, tv[i].id, tv[i].vld, tv[i].tmo, tv[i].hc);
        end

        // Fixed-priority sweep
        mode = 1'b0;
        for (int r = 1; r < 256; r++) begin
            req = 8'(r); done = 1'b0;
            step();
            chk($sformatf("fix_gnt_%0h", r), 8'(1) << hb(8'(r)), hb(8'(r)), 1'b1, 1'b0, 8'd1);
            done = 1'b1;
            step();
            chk($sformatf("fix_rel_%0h", r), 8'h00, hb(8'(r)), 1'b0, 1'b0, 8'd0);
        end

        // Timeout: 16 cycles held, one-cycle pulse, re-grant after one idle cycle
        req = 8'h04; done = 1'b0;
        for (int c = 1; c <= MAX_HOLD; c++) begin
            step();
            chk($sformatf("tmo_hold%0d", c), 8'h04, 3'd2, 1'b1, 1'b0, 8'(c));
        end
        step();
        chk("tmo_pulse", 8'h00, 3'd2, 1'b0, 1'b1, 8'd0);
        step();
        chk("tmo_regrant", 8'h04, 3'd2, 1'b1, 1'b0, 8'd1);

        // Collision: done on the hold-limit edge suppresses the timeout
        for (int c = 2; c <= MAX_HOLD; c++) step();
        chk("col_at_limit", 8'h04, 3'd2, 1'b1, 1'b0, 8'd16);
        done = 1'b1;
        step();
        chk("col_release", 8'h00, 3'd2, 1'b0, 1'b0, 8'd0);
        done = 1'b0; req = 8'h00;
        step();
        chk("col_no_pulse", 8'h00, 3'd2, 1'b0, 1'b0, 8'd0);

        // Mode and non-owner changes during BUSY leave the grant alone
        mode = 1'b0; req = 8'h81;
        step();
        chk("mt_grant", 8'h80, 3'd7, 1'b1, 1'b0, 8'd1);
        mode = 1'b1; req = 8'h83;
        step();
        chk("mt_busy1", 8'h80, 3'd7, 1'b1, 1'b0, 8'd2);
        step();
        chk("mt_busy2", 8'h80, 3'd7, 1'b1, 1'b0, 8'd3);
        done = 1'b1;
        step();
        chk("mt_release", 8'h00, 3'd7, 1'b0, 1'b0, 8'd0);
        done = 1'b0; req = 8'h00; mode = 1'b0;
        step();
        chk("mt_idle", 8'h00, 3'd7, 1'b0, 1'b0, 8'd0);

        // Asynchronous reset mid-grant
        req = 8'h20;
        step();
        chk("ar_grant", 8'h20, 3'd5, 1'b1, 1'b0, 8'd1);
        #2 rst_n = 1'b0;
        #1 chk("ar_async_clear", 8'h00, 3'd0, 1'b0, 1'b0, 8'd0);
        step();
        chk("ar_held", 8'h00, 3'd0, 1'b0, 1'b0, 8'd0);
        rst_n = 1'b1; req = 8'h00;
        step();
        chk("ar_idle_after", 8'h00, 3'd0, 1'b0, 1'b0, 8'd0);
        mode = 1'b1; req = 8'h81;
        step();
        chk("ar_rr_from_reset", 8'h80, 3'd7, 1'b1, 1'b0, 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
